btn_debounce_multi: RTL and testbench

//  N-channel button conditioner for the system top; replaces the fixed two-button debouncer.
//  Per channel: 2-flop synchroniser, optional inversion, tick-sampled shift filter,

---
 rtl/btn_debounce_multi.sv | 126 ++++++++++++
 tb/tb_btn_debounce_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: per-channel 2-flop synchroniser, tick-sampled shift filter,
// debounced level with press/release pulses and a one-shot long-press pulse.

module btn_debounce_lane #(
    parameter int DEPTH      = 8,
    parameter int LONG_TICKS = 64
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic btn_out,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);
    localparam int LW = $clog2(LONG_TICKS + 1);
    localparam logic [LW-1:0] LMAX = LW'(LONG_TICKS);
    localparam logic [LW-1:0] LPRE = LW'(LONG_TICKS - 1);

    logic [DEPTH-1:0] sh;
    logic [DEPTH-1:0] sh_next;
    logic [LW-1:0]    long_cnt;

    assign sh_next = {sh[DEPTH-2:0], sample};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sh          <= '0;
            btn_out     <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (tick) begin
                sh <= sh_next;
                // Decision is taken on the freshly shifted window, not the old one.
                if (&sh_next && !btn_out) begin
                    btn_out   <= 1'b1;
                    btn_press <= 1'b1;
                end else if (~|sh_next && btn_out) begin
                    btn_out     <= 1'b0;
                    btn_release <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            long_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (!btn_out) begin
                long_cnt <= '0;
            end else if (tick && long_cnt != LMAX) begin
                // Saturation at LMAX makes the long pulse one-shot per press.
                long_cnt <= long_cnt + LW'(1);
                if (long_cnt == LPRE)
                    btn_long <= 1'b1;
            end
        end
    end
endmodule

module btn_debounce_multi #(
    parameter int CHANNELS   = 3,
    parameter int DIV        = 100000,
    parameter int DEPTH      = 8,
    parameter int LONG_TICKS = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic                tick,
    output logic [CHANNELS-1:0] btn_out,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_long
);
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [DW-1:0]       div_cnt;
    logic [CHANNELS-1:0] s1, s2;

    assign tick = (div_cnt == DLAST);

    always_ff @(posedge clk_sys) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DW'(1);
    end

    // Polarity is folded in at the first flop so everything downstream is 1 = pressed.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_in ^ {CHANNELS{INV}};
            s2 <= s1;
        end
    end

    btn_debounce_lane #(
        .DEPTH      (DEPTH),
        .LONG_TICKS (LONG_TICKS)
    ) u_lane [CHANNELS-1:0] (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .tick        (tick),
        .sample      (s2),
        .btn_out     (btn_out),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed + randomized bench for btn_debounce_multi against a run-length reference model.

module tb_btn_debounce_multi;
    localparam int CH = 3;
    localparam int DIV = 4;
    localparam int DEPTH = 4;
    localparam int LT = 3;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] btn_in = '0;
    logic          tick;
    logic [CH-1:0] btn_out, btn_press, btn_release, btn_long;

    btn_debounce_multi #(
        .CHANNELS(CH), .DIV(DIV), .DEPTH(DEPTH), .LONG_TICKS(LT), .ACTIVE_LOW(1)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .btn_in(btn_in), .tick(tick),
        .btn_out(btn_out), .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: run length of equal tick samples per channel.
    int            m_div = 0;
    logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_out = '0;
    logic          run_val [CH];
    int            run_len [CH];
    int            press_tk [CH];
    int            tk = 0;
    logic [CH-1:0] e_press = '0, e_rel = '0, e_long = '0;

    int   n_press [CH];
    int   n_rel [CH];
    int   n_long [CH];
    int   press_cyc [CH];
    int   long_cyc [CH];
    logic seen_all_press, seen_all_rel;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < CH; c++) begin
            n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
            press_cyc[c] = -1; long_cyc[c] = -1;
        end
        seen_all_press = 1'b0;
        seen_all_rel = 1'b0;
    endtask

    task automatic model_update();
        logic [CH-1:0] old_out;
        old_out = m_out;
        e_press = '0; e_rel = '0; e_long = '0;
        if (reset) begin
            m_div = 0; m_s1 = '0; m_s2 = '0; m_out = '0;
            for (int c = 0; c < CH; c++) begin
                run_val[c] = 1'b0;
                run_len[c] = DEPTH;
            end
        end else begin
            if (m_div == DIV - 1) begin
                for (int c = 0; c < CH; c++) begin
                    if (m_s2[c] == run_val[c]) begin
                        if (run_len[c] < DEPTH) run_len[c]++;
                    end else begin
                        run_val[c] = m_s2[c];
                        run_len[c] = 1;
                    end
                    if (old_out[c] && (tk - press_tk[c] == LT)) e_long[c] = 1'b1;
                    if (run_len[c] >= DEPTH && run_val[c] != old_out[c]) begin
                        m_out[c] = run_val[c];
                        if (run_val[c]) begin
                            e_press[c] = 1'b1;
                            press_tk[c] = tk;
                        end else begin
                            e_rel[c] = 1'b1;
                        end
                    end
                end
                tk++;
            end
            m_s2 = m_s1;
            m_s1 = ~btn_in;
            m_div = (m_div + 1) % DIV;
        end
    endtask

    task automatic step();
        logic [4*CH:0] obs, exp;
        @(posedge clk_sys);
        model_update();
        #1;
        cyc++;
        obs = {tick, btn_out, btn_press, btn_release, btn_long};
        exp = {(m_div == DIV - 1), m_out, e_press, e_rel, e_long};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL cycle%0d tick/out/press/rel/long observed=%b expected=%b", cyc, obs, exp);
        end
        for (int c = 0; c < CH; c++) begin
            if (btn_press[c] === 1'b1) begin n_press[c]++; press_cyc[c] = cyc; end
            if (btn_release[c] === 1'b1) n_rel[c]++;
            if (btn_long[c] === 1'b1) begin n_long[c]++; long_cyc[c] = cyc; end
        end
        if (btn_press === 3'b111) seen_all_press = 1'b1;
        if (btn_release === 3'b111) seen_all_rel = 1'b1;
    endtask

    initial begin
        int k;
        int idx;
        for (int c = 0; c < CH; c++) begin
            run_val[c] = 1'b0; run_len[c] = DEPTH; press_tk[c] = 0;
        end
        clr();

        // 1: reset with all raw lines low, then only ch0 pressed
        reset = 1'b1; btn_in = 3'b000;
        repeat (5) step();
        chk("rst_outputs", int'({btn_out, btn_press, btn_release, btn_long}), 0);
        reset = 1'b0; btn_in = 3'b110; clr();
        repeat (24) step();
        chk("p1_out", int'(btn_out), 1);
        chk("p1_press0", n_press[0], 1);
        chk("p1_press_cycle", press_cyc[0], 5 + 4 * DIV);

        // 2: ch1 glitch of two ticks
        clr(); btn_in[1] = 1'b0;
        repeat (2 * DIV) step();
        btn_in[1] = 1'b1;
        repeat (24) step();
        chk("glitch_press1", n_press[1], 0);
        chk("glitch_rel1", n_rel[1], 0);

        // 3: long hold on ch2
        clr(); btn_in[2] = 1'b0;
        repeat (48) step();
        chk("hold_press2", n_press[2], 1);
        chk("hold_long2", n_long[2], 1);
        chk("long_gap2", long_cyc[2] - press_cyc[2], LT * DIV);
        clr(); btn_in[2] = 1'b1;
        repeat (24) step();
        chk("hold_rel2", n_rel[2], 1);
        chk("hold_nolong2", n_long[2], 0);

        // 4: all channels together
        btn_in = 3'b111;
        repeat (24) step();
        clr(); btn_in = 3'b000;
        repeat (24) step();
        chk("all_press", int'(seen_all_press), 1);
        clr(); btn_in = 3'b111;
        repeat (24) step();
        chk("all_release", int'(seen_all_rel), 1);

        // 5: reset while ch0 held
        btn_in = 3'b110;
        k = 0;
        while (btn_out[0] !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("p5_reach_press", int'(btn_out[0]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("p5_out_cleared", int'(btn_out), 0);
        chk("p5_no_release", int'(btn_release), 0);
        clr();
        repeat (24) step();
        chk("p5_no_release_after", n_rel[0], 0);
        chk("p5_repress", n_press[0], 1);

        // 6: tick spacing after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("tick_k0", int'(tick), 0);
        for (int j = 1; j < 20; j++) begin
            step();
            chk("tick_spacing", int'(tick), int'((j % DIV) == DIV - 1));
        end

        // 7: randomized activity with occasional reset
        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(0, 19) == 0) begin
                idx = $urandom_range(0, CH - 1);
                btn_in[idx] = ~btn_in[idx];
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
